step_motor_drv: RTL and testbench

STEP_MOTOR_DRV -- requirements
Module: step_motor_drv

---
 rtl/step_motor_drv.sv | 153 +++++++++++++++
 tb/tb_step_motor_drv.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_motor_drv.sv
// Step/direction pulse generator: bounded or unbounded runs, stop, remain overwrite, limit switches.
// Latency: s_state and o_drive rise one clk after s_start; limit switches seen C_SYNC_STAGES clks after zpd/tpd.
// Backpressure: none; s_start during RUN and stop/remain strobes during IDLE are dropped.
module step_motor_drv #(
   parameter int C_STEP_NUMBER_WIDTH = 32,
   parameter int C_SPEED_DATA_WIDTH  = 32,
   parameter int C_SYNC_STAGES       = 2
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           s_sel,
   input  logic                           s_start,
   input  logic                           s_stop,
   input  logic [C_SPEED_DATA_WIDTH-1:0]  s_speed,
   input  logic [C_STEP_NUMBER_WIDTH-1:0] s_step,
   input  logic                           s_dir,
   input  logic                           s_mod_remain,
   input  logic [C_STEP_NUMBER_WIDTH-1:0] s_new_remain,
   output logic                           s_state,
   output logic [C_STEP_NUMBER_WIDTH-1:0] s_position,
   output logic                           s_zpsign,
   output logic                           s_tpsign,
   input  logic                           zpd,
   input  logic                           tpd,
   output logic                           o_drive,
   output logic                           o_dir
);

   localparam int NW = C_STEP_NUMBER_WIDTH;
   localparam int SW = C_SPEED_DATA_WIDTH;
   localparam logic [SW-1:0] SPD_ONE = 1;
   localparam logic [SW-1:0] SPD_MIN = 2;
   localparam logic [NW-1:0] POS_ONE = 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                   state, state_nxt;
   logic [SW-1:0]            spd, spd_nxt, cnt, cnt_nxt;
   logic [NW-1:0]            remain, remain_nxt, pos_nxt;
   logic                     unbnd, unbnd_nxt, dir_nxt, drive_nxt;
   logic                     stop_pend, stop_pend_nxt;
   logic [C_SYNC_STAGES-1:0] zp_sync, tp_sync;
   logic                     start_ok, lim_hit, at_step, at_end;

   assign s_zpsign = zp_sync[C_SYNC_STAGES-1];
   assign s_tpsign = tp_sync[C_SYNC_STAGES-1];
   assign s_state  = (state == RUN);
   // A start toward an already-active limit is refused
   assign start_ok = s_sel & s_start & ~(s_dir ? s_zpsign : s_tpsign);
   assign lim_hit  = o_dir ? s_zpsign : s_tpsign;
   assign at_step  = (cnt == '0);
   assign at_end   = (cnt == spd - SPD_ONE);

   // Next-state, step bookkeeping and look-ahead of the registered pulse output
   always_comb begin
      state_nxt     = state;
      spd_nxt       = spd;
      cnt_nxt       = cnt;
      remain_nxt    = remain;
      unbnd_nxt     = unbnd;
      dir_nxt       = o_dir;
      pos_nxt       = s_position;
      stop_pend_nxt = stop_pend;
      drive_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt     = RUN;
               spd_nxt       = (s_speed < SPD_MIN) ? SPD_MIN : s_speed;
               remain_nxt    = s_step;
               unbnd_nxt     = (s_step == '0);
               dir_nxt       = s_dir;
               cnt_nxt       = '0;
               stop_pend_nxt = 1'b0;
            end
         end
         RUN: begin
            cnt_nxt = at_end ? '0 : cnt + SPD_ONE;
            if (at_step) begin
               pos_nxt = o_dir ? s_position - POS_ONE : s_position + POS_ONE;
               if (!unbnd && remain != '0) remain_nxt = remain - POS_ONE;
            end
            // Overwrite wins over the decrement of the same cycle
            if (s_mod_remain) begin
               remain_nxt = s_new_remain;
               unbnd_nxt  = 1'b0;
            end
            if (s_stop) stop_pend_nxt = 1'b1;
            if (!s_sel) begin
               state_nxt = IDLE;
               pos_nxt   = s_position;
            end else if (at_end) begin
               if (lim_hit) begin
                  state_nxt = IDLE;
                  if (o_dir) pos_nxt = '0;
               end else if (stop_pend_nxt) begin
                  state_nxt = IDLE;
               end else if (!unbnd_nxt && remain_nxt == '0) begin
                  state_nxt = IDLE;
               end
            end
            if (state_nxt == IDLE) begin
               cnt_nxt       = '0;
               stop_pend_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Pulse is high for the first half of every period, starting with the first RUN cycle
      drive_nxt = (state_nxt == RUN) && (cnt_nxt < (spd_nxt >> 1));
   end

   // Run registers; reset aborts a run mid-period
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         spd        <= '0;
         cnt        <= '0;
         remain     <= '0;
         unbnd      <= 1'b0;
         stop_pend  <= 1'b0;
         o_dir      <= 1'b0;
         o_drive    <= 1'b0;
         s_position <= '0;
      end else begin
         state      <= state_nxt;
         spd        <= spd_nxt;
         cnt        <= cnt_nxt;
         remain     <= remain_nxt;
         unbnd      <= unbnd_nxt;
         stop_pend  <= stop_pend_nxt;
         o_dir      <= dir_nxt;
         o_drive    <= drive_nxt;
         s_position <= pos_nxt;
      end
   end

   // Limit-switch synchronisers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         zp_sync <= '0;
         tp_sync <= '0;
      end else begin
         zp_sync[0] <= zpd;
         tp_sync[0] <= tpd;
         for (int i = 1; i < C_SYNC_STAGES; i++) begin
            zp_sync[i] <= zp_sync[i-1];
            tp_sync[i] <= tp_sync[i-1];
         end
      end
   end

endmodule

// File: tb/tb_step_motor_drv.sv
// Bench for step_motor_drv: vector table, directed corner sequences and randomized runs.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable.
module tb_step_motor_drv;

   localparam int NW = 32;
   localparam int SW = 32;
   localparam int NS = 2;

   logic          clk, resetn;
   logic          s_sel, s_start, s_stop, s_dir, s_mod_remain;
   logic [SW-1:0] s_speed;
   logic [NW-1:0] s_step, s_new_remain;
   logic          s_state, s_zpsign, s_tpsign, o_drive, o_dir;
   logic [NW-1:0] s_position;
   logic          zpd, tpd;

   int            checks = 0;
   int            errors = 0;
   logic [NW-1:0] exp_pos;

   typedef struct {
      logic          sel, start, stop, mod;
      logic [SW-1:0] speed;
      logic [NW-1:0] step, nrem;
      logic          dir;
      logic          e_state, e_drive, e_dir;
      logic [NW-1:0] e_pos;
   } vec_t;
   vec_t tbl[$];

   step_motor_drv #(
      .C_STEP_NUMBER_WIDTH(NW),
      .C_SPEED_DATA_WIDTH (SW),
      .C_SYNC_STAGES      (NS)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .s_sel       (s_sel),
      .s_start     (s_start),
      .s_stop      (s_stop),
      .s_speed     (s_speed),
      .s_step      (s_step),
      .s_dir       (s_dir),
      .s_mod_remain(s_mod_remain),
      .s_new_remain(s_new_remain),
      .s_state     (s_state),
      .s_position  (s_position),
      .s_zpsign    (s_zpsign),
      .s_tpsign    (s_tpsign),
      .zpd         (zpd),
      .tpd         (tpd),
      .o_drive     (o_drive),
      .o_dir       (o_dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0; s_sel = 1'b1; s_start = 1'b0; s_stop = 1'b0; s_mod_remain = 1'b0;
      s_new_remain = '0; s_speed = '0; s_step = '0; s_dir = 1'b0; zpd = 1'b0; tpd = 1'b0;
      cyc(); cyc();
      resetn = 1'b1;
      cyc();
      exp_pos = '0;
   endtask

   task automatic start_run(input int sp, input int st, input bit d);
      s_speed = SW'(sp); s_step = NW'(st); s_dir = d; s_start = 1'b1;
      cyc();
      s_start = 1'b0;
   endtask

   task automatic add(input int sel, input int start, input int stop, input int mod, input int speed,
                      input int step, input int nrem, input int dir, input int e_st, input int e_dr,
                      input int e_dir, input int e_pos);
      vec_t v;
      v.sel = 1'(sel); v.start = 1'(start); v.stop = 1'(stop); v.mod = 1'(mod);
      v.speed = SW'(speed); v.step = NW'(step); v.nrem = NW'(nrem); v.dir = 1'(dir);
      v.e_state = 1'(e_st); v.e_drive = 1'(e_dr); v.e_dir = 1'(e_dir); v.e_pos = NW'(e_pos);
      tbl.push_back(v);
   endtask

   // Reference: a run of n steps lasts n*spd cycles, the pulse is high in the first spd/2 of each period;
   // a stop during period p ends the run after period p.
   task automatic run_check(input string tag, input int speed, input int steps, input bit d, input int stop_at);
      int  sp, n, len, mism, pulses, run_cyc;
      bit  prev, exp_st, exp_dr;
      sp = (speed < 2) ? 2 : speed;
      n  = (stop_at >= 0 && (stop_at / sp + 1) < steps) ? stop_at / sp + 1 : steps;
      len = n * sp;
      mism = 0; pulses = 0; run_cyc = 0; prev = 1'b0;
      start_run(speed, steps, d);
      for (int t = 0; t < len + 4; t++) begin
         exp_st = (t < len);
         exp_dr = (t < len) && ((t % sp) < sp / 2);
         if (s_state !== exp_st || o_drive !== exp_dr) mism++;
         if (s_state === 1'b1) run_cyc++;
         if (o_drive === 1'b1 && !prev) pulses++;
         prev = (o_drive === 1'b1);
         s_stop = (t == stop_at);
         cyc();
      end
      s_stop = 1'b0;
      exp_pos = d ? exp_pos - NW'(n) : exp_pos + NW'(n);
      chk({tag, ".wave_mismatches"}, 64'(mism), 64'd0);
      chk({tag, ".pulses"}, 64'(pulses), 64'(n));
      chk({tag, ".run_cycles"}, 64'(run_cyc), 64'(len));
      chk({tag, ".position"}, 64'(s_position), 64'(exp_pos));
      chk({tag, ".o_dir"}, 64'(o_dir), 64'(d));
   endtask

   initial begin
      int  pulses, run_cyc, mism, n;
      bit  prev;

      // Reset state
      do_reset();
      chk("rst.state", 64'(s_state), 64'd0);
      chk("rst.drive", 64'(o_drive), 64'd0);
      chk("rst.dir", 64'(o_dir), 64'd0);
      chk("rst.pos", 64'(s_position), 64'd0);
      chk("rst.zpsign", 64'(s_zpsign), 64'd0);
      chk("rst.tpsign", 64'(s_tpsign), 64'd0);

      //  sel st sp md spd stp nrm dir | state drv dir pos
      add(1, 1, 0, 0,  1, 2, 0, 0,   1, 1, 0, 0);   // speed 1 clamped to 2
      add(1, 0, 0, 0,  9, 0, 0, 1,   1, 0, 0, 1);   // speed/dir changes ignored in RUN
      add(1, 0, 0, 0,  9, 0, 0, 1,   1, 1, 0, 1);
      add(1, 0, 0, 0,  9, 0, 0, 1,   1, 0, 0, 2);
      add(1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 2);
      add(1, 1, 0, 0,  4, 1, 0, 1,   1, 1, 1, 2);   // one step backward
      add(1, 1, 0, 0,  4, 1, 0, 0,   1, 1, 1, 1);   // start in RUN ignored
      add(1, 0, 0, 0,  4, 1, 0, 0,   1, 0, 1, 1);
      add(1, 0, 0, 0,  4, 1, 0, 0,   1, 0, 1, 1);
      add(1, 0, 0, 0,  4, 1, 0, 0,   0, 0, 1, 1);
      add(0, 1, 0, 0,  4, 1, 0, 0,   0, 0, 1, 1);   // start with sel=0 ignored
      add(1, 0, 1, 0,  4, 1, 0, 0,   0, 0, 1, 1);   // stop in IDLE ignored
      add(1, 0, 0, 1,  4, 1, 5, 0,   0, 0, 1, 1);   // remain strobe in IDLE ignored
      add(1, 1, 0, 0,  3, 0, 0, 0,   1, 1, 0, 1);   // unbounded, speed 3
      add(1, 0, 1, 0,  3, 0, 0, 0,   1, 0, 0, 2);   // stop on first cycle finishes the period
      add(1, 0, 0, 0,  3, 0, 0, 0,   1, 0, 0, 2);
      add(1, 0, 0, 0,  3, 0, 0, 0,   0, 0, 0, 2);
      add(1, 1, 0, 0, 10, 0, 0, 0,   1, 1, 0, 2);
      add(1, 0, 0, 0, 10, 0, 0, 0,   1, 1, 0, 3);
      add(0, 0, 0, 0, 10, 0, 0, 0,   0, 0, 0, 3);   // sel=0 mid-pulse forces IDLE
      add(1, 1, 0, 0,  2, 5, 0, 0,   1, 1, 0, 3);
      add(1, 0, 0, 1,  2, 5, 1, 0,   1, 0, 0, 4);   // overwrite on a step cycle: no decrement
      add(1, 0, 0, 0,  2, 5, 0, 0,   1, 1, 0, 4);
      add(1, 0, 0, 0,  2, 5, 0, 0,   1, 0, 0, 5);
      add(1, 0, 0, 0,  2, 5, 0, 0,   0, 0, 0, 5);
      foreach (tbl[i]) begin
         s_sel = tbl[i].sel; s_start = tbl[i].start; s_stop = tbl[i].stop; s_mod_remain = tbl[i].mod;
         s_speed = tbl[i].speed; s_step = tbl[i].step; s_new_remain = tbl[i].nrem; s_dir = tbl[i].dir;
         cyc();
         chk($sformatf("vec%0d.state", i), 64'(s_state), 64'(tbl[i].e_state));
         chk($sformatf("vec%0d.drive", i), 64'(o_drive), 64'(tbl[i].e_drive));
         chk($sformatf("vec%0d.dir", i), 64'(o_dir), 64'(tbl[i].e_dir));
         chk($sformatf("vec%0d.pos", i), 64'(s_position), 64'(tbl[i].e_pos));
      end

      // Speed 10, 3 steps forward
      do_reset();
      run_check("spd10", 10, 3, 1'b0, -1);
      chk("spd10.abs_pos", 64'(s_position), 64'd3);
      // Speed 1 clamps to 2
      do_reset();
      run_check("spd1", 1, 2, 1'b0, -1);
      chk("spd1.abs_pos", 64'(s_position), 64'd2);
      // Stop at cycle 9 with speed 6
      do_reset();
      run_check("stop9", 6, 100, 1'b0, 9);

      // Unbounded backward run, remain overwritten to 2 after the 5th pulse
      do_reset();
      start_run(8, 0, 1'b1);
      pulses = 0; run_cyc = 0; mism = 0; prev = 1'b0;
      for (int t = 0; t < 70; t++) begin
         if (s_state !== (t < 56) || o_drive !== ((t < 56) && ((t % 8) < 4))) mism++;
         if (s_state === 1'b1) run_cyc++;
         if (o_drive === 1'b1 && !prev) pulses++;
         prev = (o_drive === 1'b1);
         s_mod_remain = (t == 36);
         s_new_remain = NW'(2);
         cyc();
      end
      s_mod_remain = 1'b0;
      chk("mod.wave_mismatches", 64'(mism), 64'd0);
      chk("mod.pulses", 64'(pulses), 64'd7);
      chk("mod.run_cycles", 64'(run_cyc), 64'd56);
      chk("mod.position", 64'(s_position), 64'h0000_0000_FFFF_FFF9);

      // Zero limit during a backward run
      do_reset();
      start_run(8, 0, 1'b1);
      repeat (20) cyc();
      chk("zlim.pos_before", 64'(s_position), 64'h0000_0000_FFFF_FFFD);
      zpd = 1'b1;
      chk("zlim.sync0", 64'(s_zpsign), 64'd0);
      cyc();
      chk("zlim.sync1", 64'(s_zpsign), 64'd0);
      cyc();
      chk("zlim.sync2", 64'(s_zpsign), 64'd1);
      chk("zlim.still_run", 64'(s_state), 64'd1);
      n = 0;
      while (s_state === 1'b1 && n < 12) begin
         cyc();
         n++;
      end
      chk("zlim.cycles_to_idle", 64'(n), 64'd2);
      chk("zlim.pos_zeroed", 64'(s_position), 64'd0);
      chk("zlim.drive", 64'(o_drive), 64'd0);
      start_run(8, 0, 1'b1);
      chk("zlim.start_back_ignored", 64'(s_state), 64'd0);
      start_run(4, 0, 1'b0);
      chk("zlim.start_fwd_runs", 64'(s_state), 64'd1);
      chk("zlim.fwd_dir", 64'(o_dir), 64'd0);
      repeat (4) cyc();
      chk("tlim.pos_before", 64'(s_position), 64'd1);
      tpd = 1'b1;
      n = 0;
      while (s_state === 1'b1 && n < 12) begin
         cyc();
         n++;
      end
      chk("tlim.cycles_to_idle", 64'(n), 64'd4);
      chk("tlim.pos_held", 64'(s_position), 64'd2);
      chk("tlim.tpsign", 64'(s_tpsign), 64'd1);
      start_run(4, 0, 1'b0);
      chk("tlim.start_fwd_ignored", 64'(s_state), 64'd0);
      zpd = 1'b0; tpd = 1'b0;

      // Asynchronous reset mid-pulse
      do_reset();
      start_run(10, 0, 1'b0);
      cyc();
      chk("arst.drive_before", 64'(o_drive), 64'd1);
      chk("arst.pos_before", 64'(s_position), 64'd1);
      #1 resetn = 1'b0;
      #1;
      chk("arst.state", 64'(s_state), 64'd0);
      chk("arst.drive", 64'(o_drive), 64'd0);
      chk("arst.pos", 64'(s_position), 64'd0);
      cyc();
      resetn = 1'b1;
      cyc(); cyc();
      chk("arst.needs_start", 64'(s_state), 64'd0);

      // Randomized runs against the reference
      do_reset();
      for (int r = 0; r < 25; r++) begin
         int sp, st, so, clamp;
         bit d;
         sp = int'($urandom_range(0, 12));
         st = int'($urandom_range(1, 5));
         d  = 1'($urandom_range(0, 1));
         clamp = (sp < 2) ? 2 : sp;
         so = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, st * clamp + 2)) : -1;
         run_check($sformatf("rnd%0d", r), sp, st, d, so);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
